// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ctrl_pkg
// Description : Shared definitions for the control_fsm instruction sequencer:
//               opcode values, ALU operation codes, the sequencer state
//               encoding and the opcode class used by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Opcode values (low three bits of the opcode field).
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_MV   = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_REP  = 3'b111;

  // ALU operation codes driven on alu_op.
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_LDA  = 3'd2,
    S_EXE  = 3'd3,
    S_WB   = 3'd4,
    S_MOV  = 3'd5,
    S_OUTS = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  // Instruction classes that share a state path.
  typedef enum logic [2:0] {
    C_ALU = 3'd0,  // ADD / SUB / NAND
    C_LDI = 3'd1,
    C_REP = 3'd2,
    C_MV  = 3'd3,
    C_OUT = 3'd4,
    C_ILL = 3'd5
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder
// Description : Binary to one-hot decoder, bit i of onehot set when value==i.
// Ports       : value  in  W       binary index
//               onehot out 2**W    one-hot result
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder #(
  parameter int W = 3
) (
  input  logic [W-1:0]      value,
  output logic [2**W-1:0]   onehot
);

  localparam int N = 2**W;

  assign onehot = {{(N-1){1'b0}}, 1'b1} << value;

endmodule
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Instruction sequencer for the register-file processor.
//               Latches an instruction on run, then walks a decode/execute
//               state machine that drives the datapath strobes.
// Ports       : clock    in   rising-edge clock
//               resetn   in   asynchronous active-low reset
//               run      in   start request (sampled in IDLE / final states)
//               instr    in   instruction {op, ra, rb}
//               busy     out  high outside IDLE
//               done     out  pulse in the final state of an instruction
//               illegal  out  pulse in ERR
//               reg_sel  out  one-hot register-to-bus select
//               imm_sel  out  immediate-to-bus select
//               g_sel    out  G-to-bus select
//               reg_en   out  one-hot register write enable
//               a_en     out  A latch enable
//               a_clr    out  load zero into A
//               g_en     out  G latch enable
//               alu_op   out  00 add, 01 sub, 10 nand
//               out_en   out  output-port strobe
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm
  import ctrl_pkg::*;
#(
  parameter  int REG_ADDR_W = 3,
  parameter  int OP_W       = 3,
  localparam int NUM_REGS   = 2**REG_ADDR_W,
  localparam int IR_W       = OP_W + 2*REG_ADDR_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                run,
  input  logic [IR_W-1:0]     instr,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [NUM_REGS-1:0] reg_sel,
  output logic                imm_sel,
  output logic                g_sel,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                a_en,
  output logic                a_clr,
  output logic                g_en,
  output logic [1:0]          alu_op,
  output logic                out_en
);

  state_t          state, state_nx;
  logic [IR_W-1:0] ir, ir_nx;
  logic            accept;

  // Legal opcodes have every bit above the low three cleared.
  function automatic op_class_t classify(input logic [OP_W-1:0] o);
    op_class_t c;
    c = C_ILL;
    if ((o >> 3) == '0) begin
      case (o[2:0])
        OP_ADD, OP_SUB, OP_NAND: c = C_ALU;
        OP_MV:                   c = C_MV;
        OP_OUT:                  c = C_OUT;
        OP_LDI:                  c = C_LDI;
        OP_REP:                  c = C_REP;
        default:                 c = C_ILL;
      endcase
    end
    return c;
  endfunction

  function automatic logic [1:0] alu_code(input logic [OP_W-1:0] o);
    logic [1:0] a;
    a = ALU_ADD;
    if (classify(o) == C_ALU) begin
      if (o[2:0] == OP_SUB)       a = ALU_SUB;
      else if (o[2:0] == OP_NAND) a = ALU_NAND;
    end
    return a;
  endfunction

  // run is honoured only when no instruction is in flight or one is finishing.
  assign accept = run && (state inside {S_IDLE, S_WB, S_MOV, S_OUTS, S_ERR});
  assign ir_nx  = accept ? instr : ir;

  // Fields of the current instruction (drives the DEC branch).
  logic [OP_W-1:0] op_cur;
  assign op_cur = ir[IR_W-1 -: OP_W];

  // Fields of the instruction that will be held after this edge. Outputs are
  // registered, so they are decoded from the upcoming state and ir; this keeps
  // them a pure function of (state, ir) one cycle later.
  logic [OP_W-1:0]       op_nx;
  logic [REG_ADDR_W-1:0] ra_nx, rb_nx;
  logic [NUM_REGS-1:0]   ra_oh, rb_oh;
  op_class_t             cls_nx;

  assign op_nx  = ir_nx[IR_W-1 -: OP_W];
  assign ra_nx  = ir_nx[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign rb_nx  = ir_nx[REG_ADDR_W-1:0];
  assign cls_nx = classify(op_nx);

  onehot_decoder #(.W(REG_ADDR_W)) u_ra_dec (.value(ra_nx), .onehot(ra_oh));
  onehot_decoder #(.W(REG_ADDR_W)) u_rb_dec (.value(rb_nx), .onehot(rb_oh));

  always_comb begin
    state_nx = S_IDLE;
    if (accept) begin
      state_nx = S_DEC;
    end else begin
      case (state)
        S_DEC: begin
          case (classify(op_cur))
            C_ALU, C_LDI, C_REP: state_nx = S_LDA;
            C_MV:                state_nx = S_MOV;
            C_OUT:               state_nx = S_OUTS;
            default:             state_nx = S_ERR;
          endcase
        end
        S_LDA:   state_nx = S_EXE;
        S_EXE:   state_nx = S_WB;
        default: state_nx = S_IDLE;  // IDLE, final states, unknown encodings
      endcase
    end
  end

  logic                busy_d, done_d, illegal_d, imm_sel_d, g_sel_d;
  logic                a_en_d, a_clr_d, g_en_d, out_en_d;
  logic [NUM_REGS-1:0] reg_sel_d, reg_en_d;
  logic [1:0]          alu_op_d;

  always_comb begin
    busy_d    = (state_nx != S_IDLE);
    done_d    = 1'b0;
    illegal_d = 1'b0;
    reg_sel_d = '0;
    imm_sel_d = 1'b0;
    g_sel_d   = 1'b0;
    reg_en_d  = '0;
    a_en_d    = 1'b0;
    a_clr_d   = 1'b0;
    g_en_d    = 1'b0;
    alu_op_d  = ALU_ADD;
    out_en_d  = 1'b0;
    case (state_nx)
      S_LDA: begin
        a_en_d = 1'b1;
        // LDI and REP start from A=0 so the ALU passes the bus value through.
        if (cls_nx == C_ALU) reg_sel_d = ra_oh;
        else                 a_clr_d   = 1'b1;
      end
      S_EXE: begin
        g_en_d   = 1'b1;
        alu_op_d = alu_code(op_nx);
        if (cls_nx == C_LDI) imm_sel_d = 1'b1;
        else                 reg_sel_d = rb_oh;
      end
      S_WB: begin
        g_sel_d  = 1'b1;
        reg_en_d = ra_oh;
        done_d   = 1'b1;
      end
      S_MOV: begin
        reg_sel_d = rb_oh;
        reg_en_d  = ra_oh;
        done_d    = 1'b1;
      end
      S_OUTS: begin
        reg_sel_d = ra_oh;
        out_en_d  = 1'b1;
        done_d    = 1'b1;
      end
      S_ERR: begin
        illegal_d = 1'b1;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      ir      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      reg_sel <= '0;
      imm_sel <= 1'b0;
      g_sel   <= 1'b0;
      reg_en  <= '0;
      a_en    <= 1'b0;
      a_clr   <= 1'b0;
      g_en    <= 1'b0;
      alu_op  <= ALU_ADD;
      out_en  <= 1'b0;
    end else begin
      state   <= state_nx;
      ir      <= ir_nx;
      busy    <= busy_d;
      done    <= done_d;
      illegal <= illegal_d;
      reg_sel <= reg_sel_d;
      imm_sel <= imm_sel_d;
      g_sel   <= g_sel_d;
      reg_en  <= reg_en_d;
      a_en    <= a_en_d;
      a_clr   <= a_clr_d;
      g_en    <= g_en_d;
      alu_op  <= alu_op_d;
      out_en  <= out_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_fsm
// Description : Self-checking bench for control_fsm (default build and a
//               REG_ADDR_W=4 build): directed vector table, multi-cycle
//               sequences and randomized issue against a schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] reg_sel;
    logic        imm_sel;
    logic        g_sel;
    logic [15:0] reg_en;
    logic        a_en;
    logic        a_clr;
    logic        g_en;
    logic [1:0]  alu_op;
    logic        out_en;
  } out_t;

  typedef struct {
    string      name;
    logic [8:0] instr;
    int         cyc;
    out_t       exp;
  } vec_t;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // Default build
  logic       run;
  logic [8:0] instr;
  logic       busy, done, illegal, imm_sel, g_sel, a_en, a_clr, g_en, out_en;
  logic [7:0] reg_sel, reg_en;
  logic [1:0] alu_op;

  control_fsm dut (
    .clock(clock), .resetn(resetn), .run(run), .instr(instr),
    .busy(busy), .done(done), .illegal(illegal), .reg_sel(reg_sel),
    .imm_sel(imm_sel), .g_sel(g_sel), .reg_en(reg_en), .a_en(a_en),
    .a_clr(a_clr), .g_en(g_en), .alu_op(alu_op), .out_en(out_en)
  );

  // Wide-register build
  logic        run4;
  logic [10:0] instr4;
  logic        busy4, done4, illegal4, imm_sel4, g_sel4, a_en4, a_clr4, g_en4, out_en4;
  logic [15:0] reg_sel4, reg_en4;
  logic [1:0]  alu_op4;

  control_fsm #(.REG_ADDR_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .run(run4), .instr(instr4),
    .busy(busy4), .done(done4), .illegal(illegal4), .reg_sel(reg_sel4),
    .imm_sel(imm_sel4), .g_sel(g_sel4), .reg_en(reg_en4), .a_en(a_en4),
    .a_clr(a_clr4), .g_en(g_en4), .alu_op(alu_op4), .out_en(out_en4)
  );

  int   vectors = 0;
  int   miscompares = 0;
  out_t model_q[$];
  vec_t vecs[15];

  function automatic out_t rec(input logic bz, input logic dn, input logic il,
                               input logic [15:0] rs, input logic im, input logic gs,
                               input logic [15:0] re, input logic ae, input logic ac,
                               input logic ge, input logic [1:0] ao, input logic oe);
    out_t r;
    r = '{bz, dn, il, rs, im, gs, re, ae, ac, ge, ao, oe};
    return r;
  endfunction

  function automatic out_t sample3();
    return '{busy, done, illegal, {8'h00, reg_sel}, imm_sel, g_sel, {8'h00, reg_en},
             a_en, a_clr, g_en, alu_op, out_en};
  endfunction

  function automatic out_t sample4();
    return '{busy4, done4, illegal4, reg_sel4, imm_sel4, g_sel4, reg_en4,
             a_en4, a_clr4, g_en4, alu_op4, out_en4};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected per-cycle outputs of one instruction, cycles 1..N after accept.
  task automatic build(input int aw, input logic [10:0] ins);
    int          op, ra, rb;
    logic [15:0] ra_oh, rb_oh;
    out_t        r;
    op    = int'((ins >> (2*aw)) & 11'h7);
    ra    = int'((ins >> aw) & 11'((1 << aw) - 1));
    rb    = int'(ins & 11'((1 << aw) - 1));
    ra_oh = 16'(1) << ra;
    rb_oh = 16'(1) << rb;
    model_q.delete();
    r = '0; r.busy = 1'b1;
    model_q.push_back(r);                                    // decode
    if (op <= 2 || op == 5 || op == 7) begin
      r = '0; r.busy = 1'b1; r.a_en = 1'b1;                  // load A
      if (op <= 2) r.reg_sel = ra_oh; else r.a_clr = 1'b1;
      model_q.push_back(r);
      r = '0; r.busy = 1'b1; r.g_en = 1'b1;                  // execute
      r.alu_op = (op <= 2) ? 2'(op) : 2'b00;
      if (op == 5) r.imm_sel = 1'b1; else r.reg_sel = rb_oh;
      model_q.push_back(r);
      r = '0; r.busy = 1'b1; r.g_sel = 1'b1; r.reg_en = ra_oh; r.done = 1'b1;
      model_q.push_back(r);
    end else begin
      r = '0; r.busy = 1'b1; r.done = 1'b1;
      if (op == 3) begin r.reg_sel = rb_oh; r.reg_en = ra_oh; end
      else if (op == 4) begin r.reg_sel = ra_oh; r.out_en = 1'b1; end
      else r.illegal = 1'b1;
      model_q.push_back(r);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    run = 1'b0;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy still %b expected 0", busy);
    end
  endtask

  task automatic rand_run(input int aw, input int n);
    out_t cur;
    logic r;
    logic [10:0] ins;
    cur = '0;
    model_q.delete();
    for (int i = 0; i < n; i++) begin
      r   = ($urandom_range(0, 2) != 0);
      ins = 11'($urandom);
      if (aw == 3) begin
        ins = {2'b00, ins[8:0]};
        run = r; instr = ins[8:0];
      end else begin
        run4 = r; instr4 = ins;
      end
      if ((!cur.busy || cur.done) && r) build(aw, ins);
      if (model_q.size() > 0) cur = model_q.pop_front();
      else cur = '0;
      tick();
      if (aw == 3) check("rand3", sample3(), cur);
      else         check("rand4", sample4(), cur);
    end
    run = 1'b0;
    run4 = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"add_dec",  9'b000_010_011, 1, rec(1,0,0,16'h00,0,0,16'h00,0,0,0,2'b00,0)};
    vecs[1]  = '{"add_lda",  9'b000_010_011, 2, rec(1,0,0,16'h04,0,0,16'h00,1,0,0,2'b00,0)};
    vecs[2]  = '{"add_exe",  9'b000_010_011, 3, rec(1,0,0,16'h08,0,0,16'h00,0,0,1,2'b00,0)};
    vecs[3]  = '{"add_wb",   9'b000_010_011, 4, rec(1,1,0,16'h00,0,1,16'h04,0,0,0,2'b00,0)};
    vecs[4]  = '{"ldi_lda",  9'b101_101_000, 2, rec(1,0,0,16'h00,0,0,16'h00,1,1,0,2'b00,0)};
    vecs[5]  = '{"ldi_exe",  9'b101_101_000, 3, rec(1,0,0,16'h00,1,0,16'h00,0,0,1,2'b00,0)};
    vecs[6]  = '{"ldi_wb",   9'b101_101_000, 4, rec(1,1,0,16'h00,0,1,16'h20,0,0,0,2'b00,0)};
    vecs[7]  = '{"out_r7",   9'b100_111_000, 2, rec(1,1,0,16'h80,0,0,16'h00,0,0,0,2'b00,1)};
    vecs[8]  = '{"illegal",  9'b110_001_010, 2, rec(1,1,1,16'h00,0,0,16'h00,0,0,0,2'b00,0)};
    vecs[9]  = '{"mv_r3r3",  9'b011_011_011, 2, rec(1,1,0,16'h08,0,0,16'h08,0,0,0,2'b00,0)};
    vecs[10] = '{"sub_exe",  9'b001_001_010, 3, rec(1,0,0,16'h04,0,0,16'h00,0,0,1,2'b01,0)};
    vecs[11] = '{"nand_lda", 9'b010_110_000, 2, rec(1,0,0,16'h40,0,0,16'h00,1,0,0,2'b00,0)};
    vecs[12] = '{"nand_exe", 9'b010_110_000, 3, rec(1,0,0,16'h01,0,0,16'h00,0,0,1,2'b10,0)};
    vecs[13] = '{"rep_lda",  9'b111_100_111, 2, rec(1,0,0,16'h00,0,0,16'h00,1,1,0,2'b00,0)};
    vecs[14] = '{"rep_wb",   9'b111_100_111, 4, rec(1,1,0,16'h00,0,1,16'h10,0,0,0,2'b00,0)};

    resetn = 1'b0; run = 1'b0; instr = '0; run4 = 1'b0; instr4 = '0;
    repeat (2) tick();
    check("reset", sample3(), '0);
    check("reset4", sample4(), '0);
    resetn = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      wait_idle();
      run = 1'b1; instr = vecs[i].instr;
      tick();
      run = 1'b0;
      repeat (vecs[i].cyc - 1) tick();
      check(vecs[i].name, sample3(), vecs[i].exp);
    end

    // Back-to-back SUB R1,R2 then NAND R6,R0 with run held high throughout
    wait_idle();
    run = 1'b1; instr = 9'b001_001_010;
    tick();                                   // c1
    instr = 9'b010_110_000;
    tick(); tick();                           // c3
    check("b2b_sub_exe", sample3(), rec(1,0,0,16'h04,0,0,16'h00,0,0,1,2'b01,0));
    tick();                                   // c4
    check("b2b_sub_wb", sample3(), rec(1,1,0,16'h00,0,1,16'h02,0,0,0,2'b00,0));
    tick();                                   // c5: second decode
    run = 1'b0;
    check("b2b_nand_dec", sample3(), rec(1,0,0,16'h00,0,0,16'h00,0,0,0,2'b00,0));
    tick(); tick();                           // c7
    check("b2b_nand_exe", sample3(), rec(1,0,0,16'h01,0,0,16'h00,0,0,1,2'b10,0));
    tick();                                   // c8
    check("b2b_nand_wb", sample3(), rec(1,1,0,16'h00,0,1,16'h40,0,0,0,2'b00,0));

    // Reset in the middle of an ADD, then a normal MV
    wait_idle();
    run = 1'b1; instr = 9'b000_010_011;
    tick();
    run = 1'b0;
    tick(); tick();                           // c3 EXE
    check("rst_pre_exe", sample3(), rec(1,0,0,16'h08,0,0,16'h00,0,0,1,2'b00,0));
    #1 resetn = 1'b0;
    #1 check("rst_async", sample3(), '0);
    tick();
    check("rst_hold", sample3(), '0);
    resetn = 1'b1;
    tick();
    check("rst_release_idle", sample3(), '0);
    run = 1'b1; instr = 9'b011_001_010;
    tick();
    run = 1'b0;
    tick();
    check("rst_mv", sample3(), rec(1,1,0,16'h04,0,0,16'h02,0,0,0,2'b00,0));

    // Wide build: ADD R12,R1 with a run pulse during EXE that must be ignored
    run4 = 1'b1; instr4 = 11'b000_1100_0001;
    tick();
    run4 = 1'b0;
    tick();
    check("w4_lda", sample4(), rec(1,0,0,16'h1000,0,0,16'h0000,1,0,0,2'b00,0));
    tick();
    check("w4_exe", sample4(), rec(1,0,0,16'h0002,0,0,16'h0000,0,0,1,2'b00,0));
    run4 = 1'b1; instr4 = 11'b011_0001_0010;
    tick();
    run4 = 1'b0;
    check("w4_wb", sample4(), rec(1,1,0,16'h0000,0,1,16'h1000,0,0,0,2'b00,0));
    tick();
    check("w4_idle", sample4(), '0);

    // Randomized issue against the schedule model
    wait_idle();
    rand_run(3, 400);
    rand_run(4, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
